// File: rtl/demux_pkg.sv
// Shared types and constants for the demux channel scanner.
// next_channel is the reference round-robin search over the live channels.
package demux_pkg;

  localparam int NUM_CH = 6;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] IDLE_SEL = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    GAP
  } state_t;

  // Nearest enabled channel above cur, else the lowest enabled one.
  function automatic logic [SEL_W-1:0] next_channel(
    input logic [NUM_CH-1:0] mask,
    input logic [SEL_W-1:0]  cur
  );
    logic [SEL_W-1:0] lo;
    logic [SEL_W-1:0] hi;
    logic             hf;
    lo = IDLE_SEL;
    hi = IDLE_SEL;
    hf = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lo = SEL_W'(i);
        if (i > int'(cur)) begin
          hi = SEL_W'(i);
          hf = 1'b1;
        end
      end
    end
    return hf ? hi : lo;
  endfunction

endpackage

// File: rtl/demux_scan_ctrl_if.sv
// Control and status bundle between a scan master and the scanner.
// The master issues start/stop and config; the scanner drives the demux.
interface demux_scan_ctrl_if #(
  parameter int NUM_CH  = 6,
  parameter int DWELL_W = 16
);
  logic               start;
  logic               stop;
  logic               continuous;
  logic [NUM_CH-1:0]  ch_mask;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         sel_o;
  logic               gate_o;
  logic               busy;
  logic               done;
  logic               sweep_o;
  logic [2:0]         cur_ch;

  modport master (
    output start, stop, continuous, ch_mask, dwell,
    input  sel_o, gate_o, busy, done, sweep_o, cur_ch
  );

  modport slave (
    input  start, stop, continuous, ch_mask, dwell,
    output sel_o, gate_o, busy, done, sweep_o, cur_ch
  );
endinterface

// File: rtl/demux_next_ch.sv
// Wrap-around priority encoder: nearest enabled channel above cur.
// hi_found is low when the search wrapped to the lowest enabled channel.
module demux_next_ch #(
  parameter int NUM_CH = 6
) (
  input  logic [NUM_CH-1:0]            mask,
  input  logic [demux_pkg::SEL_W-1:0]  cur,
  output logic [demux_pkg::SEL_W-1:0]  nxt,
  output logic                         hi_found
);
  localparam int SW = demux_pkg::SEL_W;

  logic [SW-1:0] lo;
  logic [SW-1:0] hi;

  // Scan downward so the last hit is the lowest match.
  always_comb begin
    lo       = demux_pkg::IDLE_SEL;
    hi       = demux_pkg::IDLE_SEL;
    hi_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lo = SW'(i);
        if (i > int'(cur)) begin
          hi       = SW'(i);
          hi_found = 1'b1;
        end
      end
    end
    nxt = hi_found ? hi : lo;
  end

endmodule

// File: rtl/demux_scan_ctrl.sv
// Round-robin channel sequencer for the registered 1-to-8 demux.
// Each visit dwells on a channel, then blanks with sel parked on idle.
module demux_scan_ctrl
  import demux_pkg::*;
#(
  parameter int         NUM_CH     = 6,
  parameter int         DWELL_W    = 16,
  parameter int         GAP_CYCLES = 2,
  parameter logic [2:0] IDLE_SEL   = 3'd7
) (
  input logic               clk,
  input logic               rst_n,
  demux_scan_ctrl_if.slave  bus
);

  localparam logic [DWELL_W-1:0] GAP_LAST =
    DWELL_W'(GAP_CYCLES - 1);
  localparam logic [SEL_W-1:0] TOP_CH =
    SEL_W'(NUM_CH - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] len_q, len_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic               cont_q, cont_d;
  logic               stop_pend_q, stop_pend_d;

  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               gate_q, gate_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sweep_q, sweep_d;
  logic [SEL_W-1:0]   cur_q, cur_d;

  logic [SEL_W-1:0]   first_ch;
  logic [SEL_W-1:0]   next_ch;
  logic               next_hi;
  logic               first_hi;
  logic               stop_now;

  // Lowest enabled channel of the live mask input (start/restart).
  demux_next_ch #(.NUM_CH(NUM_CH)) u_first (
    .mask     (bus.ch_mask),
    .cur      (TOP_CH),
    .nxt      (first_ch),
    .hi_found (first_hi)
  );

  // Next channel within the latched mask after the current one.
  demux_next_ch #(.NUM_CH(NUM_CH)) u_next (
    .mask     (mask_q),
    .cur      (ch_q),
    .nxt      (next_ch),
    .hi_found (next_hi)
  );

  assign stop_now = stop_pend_q | bus.stop;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mask_d  = mask_q;
    cont_d  = cont_q;
    done_d  = 1'b0;
    sweep_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          mask_d = bus.ch_mask;
          cont_d = bus.continuous;
          len_d  = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
          cnt_d  = '0;
          if (|bus.ch_mask) begin
            state_d = DWELL;
            ch_d    = first_ch;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      DWELL: begin
        if (stop_now || cnt_q == len_q - 1'b1) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (stop_now) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (next_hi) begin
            state_d = DWELL;
            ch_d    = next_ch;
          end else if (cont_q && |bus.ch_mask) begin
            mask_d  = bus.ch_mask;
            state_d = DWELL;
            ch_d    = first_ch;
            sweep_d = 1'b1;
          end else begin
            mask_d  = cont_q ? bus.ch_mask : mask_q;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (state_d == IDLE) begin
      stop_pend_d = 1'b0;
    end else begin
      stop_pend_d = stop_pend_q | bus.stop;
    end

    gate_d = (state_d == DWELL);
    busy_d = (state_d != IDLE);
    sel_d  = gate_d ? ch_d : IDLE_SEL;
    cur_d  = gate_d ? ch_d : IDLE_SEL;
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      mask_q      <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      sel_q       <= IDLE_SEL;
      gate_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sweep_q     <= 1'b0;
      cur_q       <= IDLE_SEL;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      mask_q      <= mask_d;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
      sel_q       <= sel_d;
      gate_q      <= gate_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sweep_q     <= sweep_d;
      cur_q       <= cur_d;
    end
  end

  assign bus.sel_o   = sel_q;
  assign bus.gate_o  = gate_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sweep_o = sweep_q;
  assign bus.cur_ch  = cur_q;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Directed scoreboard bench for the demux channel scanner.
// Stimulus queues expected outputs; a monitor compares each cycle.
module tb_demux_scan_ctrl;

  typedef struct packed {
    logic [2:0] sel;
    logic       gate;
    logic       busy;
    logic       done;
    logic       sweep;
    logic [2:0] cur;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_scan_ctrl_if #(.NUM_CH(6), .DWELL_W(16)) bus ();

  demux_scan_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  obs_t  q[$];
  string qn[$];
  string tag = "init";
  int    checks = 0;
  int    errors = 0;

  function automatic obs_t mk(input logic [2:0] s,
                              input logic g, b, d, w);
    obs_t o;
    o.sel   = s;
    o.gate  = g;
    o.busy  = b;
    o.done  = d;
    o.sweep = w;
    o.cur   = g ? s : 3'd7;
    return o;
  endfunction

  function automatic obs_t act();
    obs_t o;
    o.sel   = bus.sel_o;
    o.gate  = bus.gate_o;
    o.busy  = bus.busy;
    o.done  = bus.done;
    o.sweep = bus.sweep_o;
    o.cur   = bus.cur_ch;
    return o;
  endfunction

  task automatic chk(input string nm, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got sel=%0d gate=%0b busy=%0b done=%0b sweep=%0b cur=%0d, want sel=%0d gate=%0b busy=%0b done=%0b sweep=%0b cur=%0d",
               nm, a.sel, a.gate, a.busy, a.done, a.sweep, a.cur,
               e.sel, e.gate, e.busy, e.done, e.sweep, e.cur);
    end
  endtask

  // Queue the outputs expected after the next edge, then step.
  task automatic t(input logic [2:0] s, input logic g, b, d, w);
    q.push_back(mk(s, g, b, d, w));
    qn.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one comparison per cycle while expectations are queued.
  initial begin
    obs_t  e;
    string n;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        n = qn.pop_front();
        chk(n, act(), e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.continuous = 1'b0;
    bus.ch_mask    = '0;
    bus.dwell      = '0;

    tag = "reset";
    t(7, 0, 0, 0, 0);
    rst_n = 1'b1;
    t(7, 0, 0, 0, 0);

    tag = "single_sweep";
    bus.ch_mask = 6'b000101;
    bus.dwell = 16'd3;
    bus.start = 1'b1;
    t(0, 1, 1, 0, 0);
    bus.start = 1'b0;
    t(0, 1, 1, 0, 0);
    t(0, 1, 1, 0, 0);
    t(7, 0, 1, 0, 0);
    t(7, 0, 1, 0, 0);
    t(2, 1, 1, 0, 0);
    t(2, 1, 1, 0, 0);
    t(2, 1, 1, 0, 0);
    t(7, 0, 1, 0, 0);
    t(7, 0, 1, 0, 0);
    t(7, 0, 0, 1, 0);
    t(7, 0, 0, 0, 0);

    tag = "single_ch_cont";
    bus.ch_mask = 6'b100000;
    bus.dwell = 16'd0;
    bus.continuous = 1'b1;
    bus.start = 1'b1;
    t(5, 1, 1, 0, 0);
    bus.start = 1'b0;
    t(7, 0, 1, 0, 0);
    t(7, 0, 1, 0, 0);
    t(5, 1, 1, 0, 1);
    t(7, 0, 1, 0, 0);
    t(7, 0, 1, 0, 0);
    t(5, 1, 1, 0, 1);
    tag = "stop_in_dwell";
    bus.stop = 1'b1;
    t(7, 0, 1, 0, 0);
    bus.stop = 1'b0;
    t(7, 0, 1, 0, 0);
    t(7, 0, 0, 1, 0);
    t(7, 0, 0, 0, 0);
    bus.continuous = 1'b0;

    tag = "empty_mask";
    bus.ch_mask = 6'b000000;
    bus.dwell = 16'd4;
    bus.start = 1'b1;
    t(7, 0, 0, 1, 0);
    bus.start = 1'b0;
    t(7, 0, 0, 0, 0);

    tag = "mask_relatch";
    bus.ch_mask = 6'b000011;
    bus.dwell = 16'd2;
    bus.continuous = 1'b1;
    bus.start = 1'b1;
    t(0, 1, 1, 0, 0);
    bus.start = 1'b0;
    t(0, 1, 1, 0, 0);
    t(7, 0, 1, 0, 0);
    t(7, 0, 1, 0, 0);
    t(1, 1, 1, 0, 0);
    bus.ch_mask = 6'b010000;
    t(1, 1, 1, 0, 0);
    t(7, 0, 1, 0, 0);
    t(7, 0, 1, 0, 0);
    t(4, 1, 1, 0, 1);
    tag = "stop_truncate";
    bus.stop = 1'b1;
    t(7, 0, 1, 0, 0);
    bus.stop = 1'b0;
    t(7, 0, 1, 0, 0);
    t(7, 0, 0, 1, 0);
    t(7, 0, 0, 0, 0);

    tag = "restart_empty";
    bus.ch_mask = 6'b000001;
    bus.dwell = 16'd1;
    bus.start = 1'b1;
    t(0, 1, 1, 0, 0);
    bus.start = 1'b0;
    bus.ch_mask = 6'b000000;
    t(7, 0, 1, 0, 0);
    t(7, 0, 1, 0, 0);
    t(7, 0, 0, 1, 0);
    t(7, 0, 0, 0, 0);
    bus.continuous = 1'b0;

    tag = "reset_mid_scan";
    bus.ch_mask = 6'b000100;
    bus.dwell = 16'd5;
    bus.start = 1'b1;
    t(2, 1, 1, 0, 0);
    bus.start = 1'b0;
    t(2, 1, 1, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", act(), mk(7, 0, 0, 0, 0));
    t(7, 0, 0, 0, 0);
    t(7, 0, 0, 0, 0);
    rst_n = 1'b1;
    t(7, 0, 0, 0, 0);
    tag = "after_reset";
    bus.ch_mask = 6'b000010;
    bus.dwell = 16'd1;
    bus.start = 1'b1;
    t(1, 1, 1, 0, 0);
    bus.start = 1'b0;
    t(7, 0, 1, 0, 0);
    t(7, 0, 1, 0, 0);
    t(7, 0, 0, 1, 0);

    tag = "start_while_busy";
    bus.ch_mask = 6'b000011;
    bus.dwell = 16'd2;
    bus.start = 1'b1;
    t(0, 1, 1, 0, 0);
    t(0, 1, 1, 0, 0);
    bus.start = 1'b0;
    t(7, 0, 1, 0, 0);
    t(7, 0, 1, 0, 0);
    t(1, 1, 1, 0, 0);
    t(1, 1, 1, 0, 0);
    bus.start = 1'b1;
    t(7, 0, 1, 0, 0);
    bus.start = 1'b0;
    t(7, 0, 1, 0, 0);
    t(7, 0, 0, 1, 0);
    tag = "start_stop_idle";
    bus.start = 1'b1;
    bus.stop = 1'b1;
    t(7, 0, 0, 0, 0);
    bus.start = 1'b0;
    bus.stop = 1'b0;
    t(7, 0, 0, 0, 0);
    t(7, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0",
               q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
